// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one combinational-read ROM between
// NREQ valid/ready requesters. Each grant produces a registered, tagged
// response on the following cycle; aggregate throughput is one read/cycle.
module rom_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 256,
    localparam int ADDRW = $clog2(DEPTH),
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*ADDRW-1:0] req_addr,
    output logic [NREQ-1:0]       req_ready,
    output logic [ADDRW-1:0]      rom_addr,
    input  logic [WIDTH-1:0]      rom_data,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    // Index of the most recently granted requester; rotation starts just above it.
    logic [IDW-1:0]   r_last;
    logic [NREQ-1:0]  r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic [IDW-1:0]   r_rsp_id;

    logic [NREQ-1:0]  w_mask;
    logic [NREQ-1:0]  w_hi;
    logic [NREQ-1:0]  w_pick;
    logic [NREQ-1:0]  w_grant;
    logic             w_any;
    logic [IDW-1:0]   w_grant_id;
    logic [ADDRW-1:0] w_grant_addr;

    // Requesters ranked strictly above the last winner form the upper half of
    // the rotation; if none of them is valid the search wraps to index 0.
    // Only comparators and one isolate-lowest-bit sit in the grant path.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
            assign w_mask[gi] = (IDW'(gi) > r_last);
        end
    endgenerate

    assign w_hi    = req_valid & w_mask;
    assign w_pick  = (|w_hi) ? w_hi : req_valid;
    assign w_grant = w_pick & (~w_pick + NREQ'(1));
    assign w_any   = |req_valid;

    // Encode the one-hot grant and steer the winner's address to the ROM.
    always_comb begin
        w_grant_id   = '0;
        w_grant_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_grant_id   = w_grant_id | IDW'(i);
                w_grant_addr = w_grant_addr | req_addr[i*ADDRW +: ADDRW];
            end
        end
    end

    // Capture the ROM word at the accepting edge and advance the rotation pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last      <= IDW'(NREQ - 1);
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
        end else begin
            r_rsp_valid <= w_grant;
            if (w_any) begin
                r_last     <= w_grant_id;
                r_rsp_data <= rom_data;
                r_rsp_id   <= w_grant_id;
            end
        end
    end

    assign req_ready = w_grant;
    assign rom_addr  = w_grant_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_rsp_id;
    assign busy      = w_any;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Round-robin arbiter that shares one single-port asynchronous ROM (combinational read, `rom_async`-style) between NREQ independent requesters. Each requester issues read requests with a valid/ready handshake and gets a registered, tagged response exactly one cycle after its grant. It sits between the ROM instance and its consumers, such as a CPU fetch port, a character/tile generator and a DMA/boot copier. Throughput is one ROM read per cycle total, distributed fairly.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: ROM data width.
- `DEPTH`, 256: ROM depth.
- `ADDRW`, $clog2(DEPTH): address width, local.
- `IDW`, $clog2(NREQ): requester index width, local.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NREQ: bit i means requester i has a pending read.
- `req_addr` in NREQ*ADDRW: requester i address in bits [i*ADDRW +: ADDRW].
- `req_ready` out NREQ: one-hot grant; bit i high means requester i's request is accepted this cycle.
- `rom_addr` out ADDRW: address to the ROM.
- `rom_data` in WIDTH: combinational ROM read data for `rom_addr`.
- `rsp_valid` out NREQ: one-hot, one-cycle pulse; bit i means `rsp_data` belongs to requester i.
- `rsp_data` out WIDTH: registered read data, shared by all requesters.
- `rsp_id` out IDW: index of the requester that owns the current response.
- `busy` out 1: high when any `req_valid` bit is high (combinational).

## Operation
- Arbitration is combinational on `req_valid` and the registered pointer `last` (IDW bits).
- Priority order is last+1, last+2, … wrapping modulo NREQ. The lowest-ranked valid requester wins.
- At most one `req_ready` bit is high per cycle. It is all-zero when `req_valid` == 0.
- A request transfers when `req_valid[i] & req_ready[i]`. The requester must hold `req_valid[i]` and its address stable until then.
- Dropping `req_valid` before grant is legal. The request is simply withdrawn.
- `rom_addr` = address of the granted requester. It is 0 when nothing is granted.
- On a grant edge:
  - `last` ← granted index.
  - `rsp_data` ← `rom_data`.
  - `rsp_id` ← granted index.
  - `rsp_valid` ← one-hot of granted index.
- With no grant, `rsp_valid` ← 0. `rsp_data` and `rsp_id` hold their previous values.
- Responses have no backpressure. Requesters must capture `rsp_data` in the cycle `rsp_valid[i]` is high.
- A requester may hold `req_valid` continuously for back-to-back reads. With competitors present, it is regranted only after every other valid requester is served.
- Fairness: a continuously asserted requester is granted within NREQ cycles.
- Requests in the same cycle are all resolved by rotation. Fixed-priority behaviour is never allowed.
- `rsp_id` and `rsp_valid` always agree whenever `rsp_valid` != 0.

## Timing
- Reset values:
  - `last` = NREQ-1, so requester 0 has top priority after reset.
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0.
  - `req_ready`, `rom_addr` and `busy` follow their combinational equations: 0 while `req_valid` = 0.
- Reset asserted mid-operation clears the registers immediately. A grant in progress produces no response. Grants in the cycle after reset deassertion follow the reset pointer.
- Latency: response in cycle N+1 for a grant in cycle N. Throughput is 1 read/cycle aggregate.
- Critical path: `req_valid`/`last` → grant → `rom_addr` mux → ROM → `rsp_data` flop. Keep the grant logic shallow.
- The ROM data is sampled at the same edge that accepts the request. No cycle exists in which `rom_addr` changes without being sampled.

## Test plan
- Reset then single request: `req_valid`=0001, addr0=0x10, ROM[0x10]=0xA5. Expect `req_ready`=0001 in cycle 0, then `rsp_valid`=0001, `rsp_id`=0, `rsp_data`=0xA5 in cycle 1, then `rsp_valid`=0.
- All four requesters held valid for 8 cycles from reset: grants 0,1,2,3,0,1,2,3, responses matching ROM[addr_i] with matching `rsp_id`, and exactly one grant per cycle.
- Requesters 1 and 3 held continuously, with 2 raised for one cycle after a grant to 1: order 1,2,3,1,3. Requester 2 is served on rotation, not starved.
- Back-to-back single requester: requester 2 reads addresses 0..5 on consecutive cycles. Expect 6 contiguous `rsp_valid`=0100 pulses with data ROM[0..5] and no bubbles.
- Withdrawal: requester 1 valid for one cycle while 0 is granted, then dropped. Requester 1 never gets `req_ready`, and no `rsp_valid[1]` appears.
- Reset mid-stream: assert `rst` asynchronously between edges during a grant to 3. Outputs are 0 immediately, no response for that grant, and the next grant goes to the lowest valid index starting from 0.
